uart_tx: RTL and testbench

- Serial transmit stage of the UART; sits directly downstream of the baud generator.
- Consumes its one-cycle-per-bit tick `BCLK` and serialises parallel bytes offered by the APB register block onto the `tx` line.
- Frame format: start bit, LSB-first data, optional parity, one or two stop bits.
- Upstream handshake is valid/ready, one frame in flight.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, legal parameter ranges and
// parity-mode constants (also used by the receive side).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_tx.sv
// UART transmit stage: serialises one accepted byte per frame onto tx,
// advancing one bit per BCLK tick from the baud generator.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BCLK,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  // Out-of-range widths are clamped into the legal window so the counters
  // below always terminate.
  localparam int DB_EFF = (DATA_BITS < DATA_BITS_MIN) ? DATA_BITS_MIN :
                          (DATA_BITS > DATA_BITS_MAX) ? DATA_BITS_MAX : DATA_BITS;
  localparam logic [2:0] IDX_LAST  = 3'(DB_EFF - 1);
  localparam logic       STOP_LAST = (STOP_BITS <= STOP_BITS_MIN) ? 1'b0 : 1'b1;
  localparam logic       PAR_INV   = (PARITY_ODD == PAR_ODD);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_d, ready_d, busy_d;
  logic                 done;

  // Next-state, datapath updates and next registered output values.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ticks are never consumed here; a tick coincident with acceptance
        // is dropped so the start bit is a full period wide.
        if (tx_valid && tx_ready) begin
          sr_d    = tx_data;
          par_d   = (^tx_data) ^ PAR_INV;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (BCLK) state_d = START;
      end
      START: begin
        if (BCLK) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (BCLK) begin
          if (idx_q == IDX_LAST) begin
            stop_d  = 1'b0;
            state_d = HAS_PAR ? PARITY : STOP;
          end else begin
            sr_d  = sr_q >> 1;
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (BCLK) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (BCLK) begin
          if (stop_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the period that the next state represents.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sr_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      idx_q    <= 3'd0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      tx       <= tx_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
    end
  end

  // Pulses in the cycle of the final stop tick; suppressed while in reset.
  assign tx_done = done & ~rst;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four configurations (8N1, 8E1, 8O1, 7N2)
// share clk/rst/BCLK; one is exercised at a time.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       BCLK;
  logic       txv [4];
  logic [7:0] txd [4];
  logic       txo [4];
  logic       rdy [4];
  logic       bsy [4];
  logic       dn  [4];

  typedef struct {
    int          id;
    logic [15:0] bits;
    int          len;
  } exp_t;

  exp_t        expq[$];
  int          done_log[$];
  int          total = 0;
  int          bad = 0;
  int          tick_cnt = 0;
  logic [15:0] hist [4];
  exp_t        mon_e;
  logic [15:0] mon_m;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(txd[0]), .tx_valid(txv[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .tx_done(dn[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(txd[1]), .tx_valid(txv[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .tx_done(dn[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(txd[2]), .tx_valid(txv[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .tx_done(dn[2]));
  uart_tx #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(txd[3][6:0]), .tx_valid(txv[3]),
    .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .tx_done(dn[3]));

  // One-cycle baud tick every 16 clocks, changed just after the rising edge.
  initial begin
    BCLK = 1'b0;
    forever begin
      repeat (15) begin @(posedge clk); #1 BCLK = 1'b0; end
      @(posedge clk); #1 BCLK = 1'b1;
    end
  end

  // Monitor: sample each line once per tick period; on tx_done compare the
  // last len samples (idle/sync period + whole frame) with the scoreboard.
  always @(negedge clk) begin
    if (BCLK) begin
      tick_cnt++;
      for (int i = 0; i < 4; i++) begin
        hist[i] = {hist[i][14:0], txo[i]};
        if (dn[i]) begin
          done_log.push_back(tick_cnt);
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL frame inst%0d: unexpected tx_done, line history %b", i, hist[i]);
          end else begin
            mon_e = expq.pop_front();
            mon_m = 16'((16'h1 << mon_e.len) - 16'h1);
            if (mon_e.id != i || (hist[i] & mon_m) != mon_e.bits) begin
              bad++;
              $display("FAIL frame inst%0d: got %b want %b (inst%0d)",
                       i, hist[i] & mon_m, mon_e.bits, mon_e.id);
            end
          end
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dn[i]) begin
          total++;
          bad++;
          $display("FAIL done_off_tick inst%0d: got tx_done=1 want 0", i);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [15:0] bits, input int len);
    exp_t e;
    e.id = id; e.bits = bits; e.len = len;
    expq.push_back(e);
  endtask

  // Offer a byte, wait for acceptance; returns at the negedge after it.
  task automatic send(input int id, input logic [7:0] d, input logic [15:0] bits,
                      input int len, input bit hold, input bit expect_frame);
    int n = 0;
    txd[id] = d;
    txv[id] = 1'b1;
    while (!rdy[id] && n < 1000) begin @(negedge clk); n++; end
    if (!rdy[id]) begin
      total++; bad++;
      $display("FAIL send_timeout inst%0d: got tx_ready=0 want 1", id);
      txv[id] = 1'b0;
      return;
    end
    if (expect_frame) push_exp(id, bits, len);
    @(negedge clk);
    if (!hold) txv[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n = 0;
    while (bsy[id] && n < 2000) begin @(negedge clk); n++; end
    if (bsy[id]) begin
      total++; bad++;
      $display("FAIL idle_timeout inst%0d: got busy=1 want 0", id);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin @(negedge clk); if (BCLK) c++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      txv[i] = 1'b0; txd[i] = 8'h00; hist[i] = '1;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(txo[0]), 16'd1);
    chk("rst_ready", 16'(rdy[0]), 16'd0);
    chk("rst_busy", 16'(bsy[0]), 16'd0);
    chk("rst_done", 16'(dn[0]), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 16'(rdy[0]), 16'd1);

    // 8N1 0xA5: sync, 0, 1,0,1,0,0,1,0,1, 1
    send(0, 8'hA5, 16'b10101001011, 11, 1'b0, 1'b1);
    chk("busy_in_frame", 16'(bsy[0]), 16'd1);
    n = 0;
    while (!dn[0] && n < 1000) begin @(negedge clk); n++; end
    chk("done_seen", 16'(dn[0]), 16'd1);
    chk("ready_at_done", 16'(rdy[0]), 16'd0);
    @(negedge clk);
    chk("ready_after_done", 16'(rdy[0]), 16'd1);
    chk("done_one_cycle", 16'(dn[0]), 16'd0);
    repeat (2) @(negedge clk);

    // 8E1 0xA5: even parity of four ones is 0
    send(1, 8'hA5, 16'b101010010101, 12, 1'b0, 1'b1);
    wait_idle(1);
    // 8O1 0x07: three ones, odd parity bit is 0
    send(2, 8'h07, 16'b101110000001, 12, 1'b0, 1'b1);
    wait_idle(2);
    // 7N2 0x55: data 1,0,1,0,1,0,1 then two stop periods
    send(3, 8'h55, 16'b10101010111, 11, 1'b0, 1'b1);
    wait_idle(3);

    // Back-to-back with tx_valid held; tx_data changes mid-frame.
    done_log.delete();
    send(0, 8'h01, 16'b10100000001, 11, 1'b1, 1'b1);
    txd[0] = 8'hFF;
    push_exp(0, 16'b10111111111, 11);
    n = 0;
    while (done_log.size() < 1 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (!rdy[0] && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    txv[0] = 1'b0;
    n = 0;
    while (done_log.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    chk("b2b_frames", 16'(done_log.size()), 16'd2);
    if (done_log.size() == 2) chk("b2b_gap_ticks", 16'(done_log[1] - done_log[0]), 16'd11);
    wait_idle(0);

    // Acceptance in a BCLK cycle: that tick must not advance the frame.
    n = 0;
    while (!(BCLK && rdy[0]) && n < 100) begin @(negedge clk); n++; end
    txd[0] = 8'h3C;
    txv[0] = 1'b1;
    push_exp(0, 16'b10001111001, 11);
    @(negedge clk);
    txv[0] = 1'b0;
    acc = tick_cnt;
    done_log.delete();
    wait_idle(0);
    chk("coincident_frames", 16'(done_log.size()), 16'd1);
    if (done_log.size() == 1) chk("coincident_done_tick", 16'(done_log[0] - acc), 16'd11);

    // Reset in the middle of data bit 3 (0xF7 has bit 3 = 0).
    send(0, 8'hF7, 16'd0, 0, 1'b0, 1'b0);
    wait_ticks(5);
    repeat (8) @(negedge clk);
    chk("data_bit3", 16'(txo[0]), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 16'(txo[0]), 16'd1);
    chk("midrst_ready", 16'(rdy[0]), 16'd0);
    chk("midrst_busy", 16'(bsy[0]), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 16'(rdy[0]), 16'd1);
    send(0, 8'hC3, 16'b10110000111, 11, 1'b0, 1'b1);
    wait_idle(0);
    repeat (40) @(negedge clk);

    chk("scoreboard_empty", 16'(expq.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
